// File: rtl/cache_arbiter.sv
// cache_arbiter: shares the single pmem line port between the I-cache
// (read-only) and the D-cache (read/write). A winner is picked in IDLE, its
// address/write line/op are latched, and one memory transaction is run at a
// time. The completion is steered back to the owning cache in the response
// cycle.

// Protocol checker, kept apart from the datapath; only simulation evaluates it.
module cache_arbiter_checker #(
  parameter int ADDR_WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  pmem_read,
  input logic                  pmem_write,
  input logic                  pmem_resp,
  input logic                  i_resp,
  input logic                  d_resp,
  input logic [ADDR_WIDTH-1:0] pmem_address
);

  // The two caches are never completed in the same cycle.
  resp_exclusive_a: assert property (@(posedge clk) disable iff (rst)
    !(i_resp && d_resp));

  // A transaction is either a read or a write, never both.
  strobe_exclusive_a: assert property (@(posedge clk) disable iff (rst)
    !(pmem_read && pmem_write));

  // An outstanding transaction keeps its strobe and address until pmem_resp.
  hold_until_resp_a: assert property (@(posedge clk) disable iff (rst)
    ((pmem_read || pmem_write) && !pmem_resp) |=>
      ((pmem_read || pmem_write) && $stable(pmem_address)));

endmodule

module cache_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  // I-cache side
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  // D-cache side
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  // physical memory side
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t                state_r;
  logic                  last_grant_d_r;  // 1: the D-cache won most recently
  logic                  op_write_r;      // latched D op: 1 write, 0 read
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [LINE_WIDTH-1:0] wdata_r;

  logic                  i_req_s;
  logic                  d_req_s;
  logic                  grant_i_s;
  logic                  grant_d_s;

  // Round-robin pick between the two candidates; only consumed in IDLE.
  always_comb begin
    i_req_s   = i_read;
    d_req_s   = d_read | d_write;
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (i_req_s && d_req_s) begin
      // Tie: the side that did not win last time goes next.
      grant_i_s = last_grant_d_r;
      grant_d_s = ~last_grant_d_r;
    end else begin
      grant_i_s = i_req_s;
      grant_d_s = d_req_s;
    end
  end

  // Arbitration FSM with the transaction latches; inputs are ignored while serving.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      last_grant_d_r <= 1'b1;
      op_write_r     <= 1'b0;
      addr_r         <= {ADDR_WIDTH{1'b0}};
      wdata_r        <= {LINE_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_i_s) begin
            addr_r         <= i_address;
            last_grant_d_r <= 1'b0;
            state_r        <= SERVE_I;
          end else if (grant_d_s) begin
            addr_r         <= d_address;
            wdata_r        <= d_wdata;
            // read+write together is handled as a write
            op_write_r     <= d_write;
            last_grant_d_r <= 1'b1;
            state_r        <= SERVE_D;
          end else begin
            state_r <= IDLE;
          end
        end
        SERVE_I, SERVE_D: begin
          // Always drop back to IDLE after a response so a requester that
          // releases its request on resp is never granted again.
          if (pmem_resp) begin
            state_r <= IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Strobes decoded from registered state; completion steered to the owner.
  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    i_rdata    = {LINE_WIDTH{1'b0}};
    d_rdata    = {LINE_WIDTH{1'b0}};
    case (state_r)
      IDLE: begin
        // pmem_resp is not owned by anyone here and is dropped.
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
      end
      SERVE_I: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          i_resp  = 1'b1;
          i_rdata = pmem_rdata;
        end else begin
          i_resp  = 1'b0;
          i_rdata = {LINE_WIDTH{1'b0}};
        end
      end
      SERVE_D: begin
        pmem_read  = ~op_write_r;
        pmem_write = op_write_r;
        if (pmem_resp) begin
          d_resp  = 1'b1;
          d_rdata = pmem_rdata;
        end else begin
          d_resp  = 1'b0;
          d_rdata = {LINE_WIDTH{1'b0}};
        end
      end
      default: begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
      end
    endcase
  end

  assign pmem_address = addr_r;
  assign pmem_wdata   = wdata_r;

  cache_arbiter_checker #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_checker (
    .clk          (clk),
    .rst          (rst),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_resp    (pmem_resp),
    .i_resp       (i_resp),
    .d_resp       (d_resp),
    .pmem_address (pmem_address)
  );

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed scenario tasks plus a randomized run checked
// against a transaction-level reference model of the arbiter.
module tb_cache_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int n_tests = 0;
  int n_fail  = 0;

  logic [LW-1:0] line_a5;
  logic [LW-1:0] line_dead;
  logic [LW-1:0] zero_line;

  // reference model: who owns memory (0 none, 1 I, 2 D), round-robin history, latches
  int            m_owner;
  bit            m_last_d;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;
  bit            m_wr;

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_line(output logic [LW-1:0] v);
    for (int j = 0; j < LW / 32; j++) v[j*32 +: 32] = $urandom;
  endtask

  // Advance the reference model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit want_i;
    bit want_d;
    if (rst) begin
      m_owner  = 0;
      m_last_d = 1'b1;
      m_addr   = '0;
      m_wdata  = '0;
      m_wr     = 1'b0;
    end else if (m_owner == 0) begin
      want_i = i_read;
      want_d = d_read || d_write;
      if (want_i && want_d) begin
        if (m_last_d) want_d = 1'b0;
        else          want_i = 1'b0;
      end
      if (want_i) begin
        m_owner  = 1;
        m_addr   = i_address;
        m_last_d = 1'b0;
      end else if (want_d) begin
        m_owner  = 2;
        m_addr   = d_address;
        m_wdata  = d_wdata;
        m_wr     = d_write;
        m_last_d = 1'b1;
      end
    end else if (pmem_resp) begin
      m_owner = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0; pmem_resp = 1'b0; pmem_rdata = line_a5;
    cyc();
    cyc();
    rst = 1'b0;
    pmem_resp = 1'b1;  // ignored in IDLE; data outputs must stay zero
    #1;
    n_tests++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {pmem_read, pmem_write, i_resp, d_resp});
    end
    n_tests++;
    if (pmem_address !== 32'h0 || pmem_wdata !== zero_line) begin
      n_fail++; $display("FAIL reset_latches: addr %h wdata %h expected zeros", pmem_address, pmem_wdata);
    end
    n_tests++;
    if (i_rdata !== zero_line || d_rdata !== zero_line) begin
      n_fail++; $display("FAIL reset_rdata: i %h d %h expected zeros", i_rdata, d_rdata);
    end
    cyc();
    pmem_resp = 1'b0;
  endtask

  task automatic test_i_read();
    i_read = 1'b1; i_address = 32'h0000_0040;
    cyc();
    for (int k = 0; k < 3; k++) begin
      pmem_resp = (k == 2); pmem_rdata = line_a5;
      #1;
      n_tests++;
      if ({pmem_read, pmem_write, i_resp, d_resp} !== {1'b1, 1'b0, (k == 2), 1'b0}) begin
        n_fail++; $display("FAIL i_read_ctrl k=%0d: got %b", k, {pmem_read, pmem_write, i_resp, d_resp});
      end
      n_tests++;
      if (pmem_address !== 32'h0000_0040) begin
        n_fail++; $display("FAIL i_read_addr k=%0d: got %h expected 00000040", k, pmem_address);
      end
      if (k == 2) begin
        n_tests++;
        if (i_rdata !== line_a5) begin
          n_fail++; $display("FAIL i_read_rdata: got %h expected %h", i_rdata, line_a5);
        end
      end
      cyc();
    end
    pmem_resp = 1'b0; i_read = 1'b0;
    #1;
    n_tests++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin
      n_fail++; $display("FAIL i_read_after: got %b expected 0000", {pmem_read, pmem_write, i_resp, d_resp});
    end
  endtask

  task automatic test_d_write();
    cyc();
    d_write = 1'b1; d_address = 32'h8000_0020; d_wdata = line_dead;
    cyc();
    for (int k = 0; k < 2; k++) begin
      pmem_resp = (k == 1);
      #1;
      n_tests++;
      if ({pmem_read, pmem_write, i_resp, d_resp} !== {1'b0, 1'b1, 1'b0, (k == 1)}) begin
        n_fail++; $display("FAIL d_write_ctrl k=%0d: got %b", k, {pmem_read, pmem_write, i_resp, d_resp});
      end
      n_tests++;
      if (pmem_address !== 32'h8000_0020 || pmem_wdata !== line_dead) begin
        n_fail++; $display("FAIL d_write_latch k=%0d: addr %h wdata %h", k, pmem_address, pmem_wdata);
      end
      cyc();
    end
    d_write = 1'b0; pmem_resp = 1'b0;
    #1;
    n_tests++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin
      n_fail++; $display("FAIL d_write_after: got %b expected 0000", {pmem_read, pmem_write, i_resp, d_resp});
    end
  endtask

  task automatic test_round_robin();
    logic [LW-1:0] r;
    bit exp_i;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    i_read = 1'b1; i_address = 32'h0000_1000;
    d_read = 1'b1; d_address = 32'h0000_2000;
    #1;
    for (int t = 0; t < 6; t++) begin
      exp_i = (t % 2 == 0);
      cyc();
      rand_line(r);
      pmem_resp = 1'b1; pmem_rdata = r;
      #1;
      n_tests++;
      if ({pmem_read, pmem_write, i_resp, d_resp} !== {1'b1, 1'b0, exp_i, !exp_i}) begin
        n_fail++; $display("FAIL rr_grant t=%0d: got %b expected I=%0d", t, {pmem_read, pmem_write, i_resp, d_resp}, exp_i);
      end
      n_tests++;
      if (pmem_address !== (exp_i ? 32'h0000_1000 : 32'h0000_2000)) begin
        n_fail++; $display("FAIL rr_addr t=%0d: got %h", t, pmem_address);
      end
      n_tests++;
      if ((exp_i ? i_rdata : d_rdata) !== r || (exp_i ? d_rdata : i_rdata) !== zero_line) begin
        n_fail++; $display("FAIL rr_rdata t=%0d: i %h d %h", t, i_rdata, d_rdata);
      end
      cyc();
      pmem_resp = 1'b0;
      #1;
      n_tests++;
      if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin
        n_fail++; $display("FAIL rr_idle_gap t=%0d: got %b expected 0000", t, {pmem_read, pmem_write, i_resp, d_resp});
      end
    end
    i_read = 1'b0; d_read = 1'b0;
    cyc();
  endtask

  task automatic test_addr_stable();
    logic [LW-1:0] w;
    d_read = 1'b1; d_address = 32'h0000_0100;
    cyc();
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        rand_line(w);
        d_address = 32'h0000_0200; d_write = 1'b1; d_wdata = w;
      end
      pmem_resp = (k == 3);
      #1;
      n_tests++;
      if ({pmem_read, pmem_write, i_resp, d_resp} !== {1'b1, 1'b0, 1'b0, (k == 3)}) begin
        n_fail++; $display("FAIL stable_ctrl k=%0d: got %b", k, {pmem_read, pmem_write, i_resp, d_resp});
      end
      n_tests++;
      if (pmem_address !== 32'h0000_0100) begin
        n_fail++; $display("FAIL stable_addr k=%0d: got %h expected 00000100", k, pmem_address);
      end
      cyc();
    end
    d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    logic [LW-1:0] r;
    i_read = 1'b1; i_address = 32'h0000_0300;
    cyc();
    #1;
    n_tests++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b1000 || pmem_address !== 32'h0000_0300) begin
      n_fail++; $display("FAIL rstmid_serving: got %b addr %h", {pmem_read, pmem_write, i_resp, d_resp}, pmem_address);
    end
    cyc();
    rst = 1'b1; i_read = 1'b0;
    cyc();
    rst = 1'b0; pmem_resp = 1'b1; pmem_rdata = line_a5;
    #1;
    n_tests++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000 || pmem_address !== 32'h0 || i_rdata !== zero_line) begin
      n_fail++; $display("FAIL rstmid_abandon: got %b addr %h", {pmem_read, pmem_write, i_resp, d_resp}, pmem_address);
    end
    cyc();
    pmem_resp = 1'b0; i_read = 1'b1; i_address = 32'h0000_0340;
    cyc();
    rand_line(r);
    pmem_resp = 1'b1; pmem_rdata = r;
    #1;
    n_tests++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b1010 || pmem_address !== 32'h0000_0340 || i_rdata !== r) begin
      n_fail++; $display("FAIL rstmid_next: got %b addr %h rdata %h", {pmem_read, pmem_write, i_resp, d_resp}, pmem_address, i_rdata);
    end
    cyc();
    i_read = 1'b0; pmem_resp = 1'b0;
  endtask

  task automatic test_spurious();
    logic [LW-1:0] r;
    cyc();
    for (int k = 0; k < 4; k++) begin
      rand_line(r);
      pmem_resp = 1'b1; pmem_rdata = r;
      #1;
      n_tests++;
      if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000 || i_rdata !== zero_line || d_rdata !== zero_line) begin
        n_fail++; $display("FAIL spurious k=%0d: got %b", k, {pmem_read, pmem_write, i_resp, d_resp});
      end
      cyc();
    end
    pmem_resp = 1'b0; i_read = 1'b1; i_address = 32'h0000_0500;
    cyc();
    pmem_resp = 1'b1;
    #1;
    n_tests++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b1010 || pmem_address !== 32'h0000_0500) begin
      n_fail++; $display("FAIL spurious_then_grant: got %b addr %h", {pmem_read, pmem_write, i_resp, d_resp}, pmem_address);
    end
    cyc();
    i_read = 1'b0; pmem_resp = 1'b0;
  endtask

  task automatic test_random();
    bit            prev_ir;
    bit            prev_dr;
    bit            e_rd, e_wr, e_ir, e_dr;
    logic [LW-1:0] e_irdata;
    logic [LW-1:0] e_drdata;
    logic [LW-1:0] tmp;
    int            sel;
    rst = 1'b1;
    cyc();
    model_step();
    rst = 1'b0; prev_ir = 1'b0; prev_dr = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!i_read || prev_ir || $urandom_range(0, 31) == 0) begin
        i_read    = ($urandom_range(0, 2) == 0);
        i_address = $urandom & 32'hFFFF_FFE0;
      end
      if (!(d_read || d_write) || prev_dr || $urandom_range(0, 31) == 0) begin
        sel       = $urandom_range(0, 7);
        d_read    = (sel == 0) || (sel == 2);
        d_write   = (sel == 1) || (sel == 2);
        d_address = $urandom & 32'hFFFF_FFE0;
        rand_line(tmp);
        d_wdata = tmp;
      end
      pmem_resp = ($urandom_range(0, 2) == 0);
      rand_line(tmp);
      pmem_rdata = tmp;
      #1;
      e_rd     = (m_owner == 1) || (m_owner == 2 && !m_wr);
      e_wr     = (m_owner == 2) && m_wr;
      e_ir     = (m_owner == 1) && pmem_resp;
      e_dr     = (m_owner == 2) && pmem_resp;
      e_irdata = e_ir ? pmem_rdata : zero_line;
      e_drdata = e_dr ? pmem_rdata : zero_line;
      n_tests++;
      if ({pmem_read, pmem_write, i_resp, d_resp} !== {e_rd, e_wr, e_ir, e_dr}) begin
        n_fail++; $display("FAIL rand_ctrl c=%0d: got %b expected %b", c, {pmem_read, pmem_write, i_resp, d_resp}, {e_rd, e_wr, e_ir, e_dr});
      end
      n_tests++;
      if (pmem_address !== m_addr) begin
        n_fail++; $display("FAIL rand_addr c=%0d: got %h expected %h", c, pmem_address, m_addr);
      end
      n_tests++;
      if (pmem_wdata !== m_wdata) begin
        n_fail++; $display("FAIL rand_wdata c=%0d: got %h expected %h", c, pmem_wdata, m_wdata);
      end
      n_tests++;
      if (i_rdata !== e_irdata || d_rdata !== e_drdata) begin
        n_fail++; $display("FAIL rand_rdata c=%0d: i %h d %h", c, i_rdata, d_rdata);
      end
      prev_ir = e_ir;
      prev_dr = e_dr;
      @(posedge clk);
      model_step();
      #1;
    end
    rst = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
  endtask

  initial begin
    line_a5   = {32{8'hA5}};
    line_dead = {8{32'hDEAD_BEEF}};
    zero_line = '0;
    test_reset();
    test_i_read();
    test_d_write();
    test_round_robin();
    test_addr_stable();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single physical-memory line port between the instruction cache (read-only) and the data cache (read/write) of the RV32I pipeline.
- Registers the winning request's address and write line, then drives one memory transaction at a time.
- Routes the completion back to the owning cache.
- Sits between the two L1 caches and the pmem/bus adapter.

Parameters:
ADDR_WIDTH, 32, byte address width of cache-line requests (line-aligned, low bits passed through unchanged)
LINE_WIDTH, 256, width of one cache line transfer in bits

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset, synchronous, active-high
i_read  input  1  I-cache line read request; held high until i_resp
i_address  input  ADDR_WIDTH  I-cache line address
i_rdata  output  LINE_WIDTH  line returned to I-cache; valid when i_resp=1
i_resp  output  1  one-cycle completion pulse to I-cache
d_read  input  1  D-cache line read request; held until d_resp
d_write  input  1  D-cache line write (writeback) request; held until d_resp
d_address  input  ADDR_WIDTH  D-cache line address
d_wdata  input  LINE_WIDTH  D-cache writeback line
d_rdata  output  LINE_WIDTH  line returned to D-cache; valid when d_resp=1
d_resp  output  1  one-cycle completion pulse to D-cache
pmem_read  output  1  memory read strobe; held until pmem_resp
pmem_write  output  1  memory write strobe; held until pmem_resp
pmem_address  output  ADDR_WIDTH  registered transaction address
pmem_wdata  output  LINE_WIDTH  registered write line
pmem_rdata  input  LINE_WIDTH  memory read line; valid with pmem_resp
pmem_resp  input  1  memory completion, one cycle per transaction

Behaviour:
- State machine states: IDLE, SERVE_I, SERVE_D. State, latched address, latched wdata, latched op (read/write) and last_grant are registers.
- Reset, on the rst edge, regardless of state or in-flight transaction:
  - state=IDLE, last_grant=D, latched address=0, latched wdata=0.
  - All outputs 0 in the cycle after the reset edge: pmem_read, pmem_write, i_resp, d_resp, pmem_address, pmem_wdata, i_rdata, d_rdata.
  - An in-flight pmem transaction is abandoned; no response is forwarded.
- IDLE:
  - Samples requests. Candidates: I if i_read; D if d_read|d_write.
  - One candidate wins the grant.
  - Both candidates present: round-robin. Grant the side not equal to last_grant. After reset, a tie goes to I.
  - On grant, at the same edge: latch that side's address; for D, also latch d_wdata and op (write if d_write, else read). Update last_grant and move to SERVE_x.
  - pmem_read/pmem_write are 0 in IDLE.
- SERVE_I:
  - pmem_read=1, pmem_write=0, pmem_address=latched address.
  - When pmem_resp=1: i_resp=1 and i_rdata=pmem_rdata in that same cycle (combinational pass-through); next state IDLE.
- SERVE_D:
  - pmem_read=(op==read), pmem_write=(op==write), pmem_address/pmem_wdata from latches.
  - On pmem_resp: d_resp=1, d_rdata=pmem_rdata (don't-care for writes, still driven); next state IDLE.
- Resp outputs: exactly one cycle high per transaction, never both in the same cycle, 0 in IDLE.
- Data outputs: i_rdata/d_rdata drive 0 when their resp is 0.
- Latency: request seen in IDLE at edge N drives pmem from cycle N+1. The response cycle is followed by at least one IDLE cycle, so a requester that drops its request after resp is never regranted spuriously. Back-to-back I then D costs exactly one IDLE cycle between transactions.
- Latched values are stable for the whole transaction. Input changes while serving are ignored.
- pmem_resp in IDLE is ignored.
- Illegal inputs, with defined handling:
  - d_read&d_write together: treated as write.
  - Request dropped before resp: the transaction still completes and the resp pulse is still issued.
- No starvation: under continuous requests from both sides, grants alternate I,D,I,D.

Test Plan:
- Single I read, pmem_resp 3 cycles after pmem_read rises, rdata=256'hA5.. → pmem_read high exactly 3 cycles with address=0x0000_0040, i_resp one cycle with i_rdata=A5.., d_resp never high.
- D writeback addr 0x8000_0020, wdata=256'hDEAD.. → pmem_write=1, pmem_read=0, pmem_wdata=DEAD.. stable until pmem_resp, d_resp one cycle.
- Both i_read and d_read asserted first cycle after reset and held → grants I, IDLE, D, IDLE, I, ... alternating; verify last_grant tie-break and no back-to-back same side.
- Change d_address from 0x100 to 0x200 mid SERVE_D → pmem_address stays 0x100 until resp.
- Assert rst during SERVE_I before pmem_resp → next cycle pmem_read=0, state IDLE; a late pmem_resp produces no i_resp; next request is served normally.
- Spurious pmem_resp while IDLE with no requests → no resp outputs, state stays IDLE.
